// File: rtl/pfir_1024x18x25x20x2.sv
// pfir_1024x18x25x20x2 -- programmable dual-channel (I/Q) polyphase FIR engine.
//
// Takes 18-bit signed complex samples and produces 20-bit signed complex
// results. Each channel has one time-shared 18x25 MAC. A pass runs program
// entries 0..ncoef+1, one per clk. Every entry with w=1 closes a polyphase
// branch and emits one result.
//
// Ports:
//   clk          sole clock
//   mrst         asynchronous active-low master reset
//   dix, diy     input I/Q sample; taken when iv && rfd
//   iv / rfd     input valid / input FIFO has a free slot
//   oe           output enable; results are released only while high
//   dox, doy     output I/Q sample; ov is a one-cycle strobe, ovf flags clipping
//   dec          accepted samples per pass (0 behaves as 1)
//   ncoef        program length minus 2
//   pdata/pwr    byte-serial program load; four 9-bit words per entry
//   prst         restart programming at entry 0, word 0
//
// The delay lines and the program RAM are not cleared by mrst.
module pfir_1024x18x25x20x2 (
    input  logic        clk,
    input  logic        mrst,
    input  logic [17:0] dix,
    input  logic [17:0] diy,
    input  logic        iv,
    output logic        rfd,
    input  logic        oe,
    output logic [19:0] dox,
    output logic [19:0] doy,
    output logic        ov,
    output logic        ovf,
    input  logic [5:0]  dec,
    input  logic [9:0]  ncoef,
    input  logic [8:0]  pdata,
    input  logic        pwr,
    input  logic        prst
);
    localparam int DATA_W = 18;
    localparam int COEF_W = 25;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = 48;
    localparam int OUT_W  = 20;
    localparam int FRAC   = 21;
    localparam int RND_W  = ACC_W + 1 - FRAC;
    localparam logic [ACC_W:0] HALF = (ACC_W+1)'(1) << (FRAC - 1);

    // round-half-up of acc / 2^FRAC, carried in one extra bit so the
    // rounding increment cannot wrap
    function automatic logic signed [RND_W-1:0] round_acc(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W:0] s;
        s = $signed({a[ACC_W-1], a}) + $signed(HALF);
        s = s >>> FRAC;
        return s[RND_W-1:0];
    endfunction

    function automatic logic clipped(input logic signed [RND_W-1:0] v);
        return !((&v[RND_W-1:OUT_W-1]) || !(|v[RND_W-1:OUT_W-1]));
    endfunction

    function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [RND_W-1:0] v);
        if (clipped(v))
            return v[RND_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        return v[OUT_W-1:0];
    endfunction

    // ---------------- program port ----------------
    // entry layout: {w, coef[24:0], off[9:0]}
    logic [1:0]  pphase;
    logic [9:0]  paddr;
    logic [8:0]  pw0, pw1, pw2;
    logic [35:0] pram [1024];
    logic        pcommit;

    assign pcommit = pwr && !prst && (pphase == 2'd3);

    always_ff @(posedge clk or negedge mrst) begin
        if (!mrst) begin
            pphase <= 2'd0;
            paddr  <= 10'd0;
        end else if (prst) begin
            pphase <= 2'd0;
            paddr  <= 10'd0;
        end else if (pwr) begin
            pphase <= pphase + 2'd1;
            if (pphase == 2'd3)
                paddr <= paddr + 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (pwr && !prst) begin
            case (pphase)
                2'd0:    pw0 <= pdata;
                2'd1:    pw1 <= pdata;
                2'd2:    pw2 <= pdata;
                default: ;
            endcase
        end
        if (pcommit)
            pram[paddr] <= {pdata, pw2, pw1, pw0};
    end

    // ---------------- input FIFO ----------------
    logic [35:0] ififo [16];
    logic [3:0]  if_wp, if_rp;
    logic [4:0]  if_cnt;
    logic        push, pop;

    assign rfd  = (if_cnt != 5'd16);
    assign push = iv && rfd;

    always_ff @(posedge clk or negedge mrst) begin
        if (!mrst) begin
            if_wp  <= 4'd0;
            if_rp  <= 4'd0;
            if_cnt <= 5'd0;
        end else begin
            if (push) if_wp <= if_wp + 4'd1;
            if (pop)  if_rp <= if_rp + 4'd1;
            if_cnt <= if_cnt + {4'd0, push} - {4'd0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            ififo[if_wp] <= {dix, diy};
    end

    // ---------------- sequencer ----------------
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;
    state_t     state, nstate;
    logic [5:0] dec_eff, load_cnt;
    logic [9:0] ent_addr;
    logic       enough, load_last, run_last, issue;

    assign dec_eff   = (dec == 6'd0) ? 6'd1 : dec;
    assign enough    = ({1'b0, if_cnt} >= dec_eff);
    assign load_last = (load_cnt == dec_eff - 6'd1);
    assign run_last  = (ent_addr == ncoef + 10'd1);

    always_ff @(posedge clk or negedge mrst) begin
        if (!mrst) begin
            state    <= S_IDLE;
            load_cnt <= 6'd0;
            ent_addr <= 10'd0;
        end else begin
            state    <= nstate;
            load_cnt <= (state == S_LOAD) ? load_cnt + 6'd1 : 6'd0;
            ent_addr <= (state == S_RUN)  ? ent_addr + 10'd1 : 10'd0;
        end
    end

    always_comb begin
        nstate = state;
        pop    = 1'b0;
        issue  = 1'b0;
        case (state)
            S_IDLE: if (enough) nstate = S_LOAD;
            S_LOAD: begin
                pop = 1'b1;
                if (load_last) nstate = S_RUN;
            end
            S_RUN: begin
                issue = 1'b1;
                // back-to-back passes skip IDLE so dec=1 keeps one input per ncoef+3 clks
                if (run_last) nstate = enough ? S_LOAD : S_IDLE;
            end
            default: nstate = S_IDLE;
        endcase
    end

    // ---------------- delay lines ----------------
    logic signed [DATA_W-1:0] dly_i [1024];
    logic signed [DATA_W-1:0] dly_q [1024];
    logic [9:0] nptr, wptr;

    assign wptr = nptr + 10'd1;

    always_ff @(posedge clk or negedge mrst) begin
        if (!mrst)    nptr <= 10'd0;
        else if (pop) nptr <= wptr;
    end

    always_ff @(posedge clk) begin
        if (pop) begin
            dly_i[wptr] <= ififo[if_rp][35:18];
            dly_q[wptr] <= ififo[if_rp][17:0];
        end
    end

    // ---------------- datapath pipeline ----------------
    logic        vld_p0, vld_p1, vld_p2, emit_p3, vld_p4, fresh;
    logic [35:0] ent_p0;
    logic        first_p0, first_p1, first_p2, w_p1, w_p2;
    logic [9:0]  rd_addr;
    logic signed [DATA_W-1:0] smp_i_p1, smp_q_p1;
    logic signed [COEF_W-1:0] coef_p1;
    logic signed [PROD_W-1:0] prod_i_p2, prod_q_p2;
    logic signed [ACC_W-1:0]  acc_i_p3, acc_q_p3, base_i, base_q;
    logic signed [RND_W-1:0]  rnd_i, rnd_q;
    logic signed [OUT_W-1:0]  res_i_p4, res_q_p4;
    logic                     ovf_p4;

    always_ff @(posedge clk or negedge mrst) begin
        if (!mrst) begin
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            emit_p3 <= 1'b0;
            vld_p4  <= 1'b0;
            fresh   <= 1'b1;
        end else begin
            vld_p0  <= issue;
            vld_p1  <= vld_p0;
            vld_p2  <= vld_p1;
            emit_p3 <= vld_p2 && w_p2;
            vld_p4  <= emit_p3;
            if (vld_p2) fresh <= w_p2;
        end
    end

    // p0: program RAM read
    always_ff @(posedge clk) begin
        ent_p0   <= pram[ent_addr];
        first_p0 <= (ent_addr == 10'd0);
    end

    // p1: delay-line read, offset 0 is the newest sample
    assign rd_addr = nptr - ent_p0[9:0];

    always_ff @(posedge clk) begin
        smp_i_p1 <= dly_i[rd_addr];
        smp_q_p1 <= dly_q[rd_addr];
        coef_p1  <= ent_p0[34:10];
        w_p1     <= ent_p0[35];
        first_p1 <= first_p0;
    end

    // p2: 18x25 multiply
    always_ff @(posedge clk) begin
        prod_i_p2 <= smp_i_p1 * coef_p1;
        prod_q_p2 <= smp_q_p1 * coef_p1;
        w_p2      <= w_p1;
        first_p2  <= first_p1;
    end

    // p3: accumulate; restart on the first entry of a pass or after a branch closed
    assign base_i = (first_p2 || fresh) ? '0 : acc_i_p3;
    assign base_q = (first_p2 || fresh) ? '0 : acc_q_p3;

    always_ff @(posedge clk) begin
        if (vld_p2) begin
            acc_i_p3 <= base_i + {{(ACC_W-PROD_W){prod_i_p2[PROD_W-1]}}, prod_i_p2};
            acc_q_p3 <= base_q + {{(ACC_W-PROD_W){prod_q_p2[PROD_W-1]}}, prod_q_p2};
        end
    end

    // p4: round and saturate
    assign rnd_i = round_acc(acc_i_p3);
    assign rnd_q = round_acc(acc_q_p3);

    always_ff @(posedge clk) begin
        res_i_p4 <= sat_out(rnd_i);
        res_q_p4 <= sat_out(rnd_q);
        ovf_p4   <= clipped(rnd_i) || clipped(rnd_q);
    end

    // ---------------- result FIFO and output ----------------
    logic [40:0] rfifo [8];
    logic [2:0]  rf_wp, rf_rp;
    logic [3:0]  rf_cnt;
    logic        rf_push, rf_pop;

    // a full FIFO drops the newcomer and keeps what it already holds
    assign rf_push = vld_p4 && (rf_cnt != 4'd8);
    assign rf_pop  = oe && (rf_cnt != 4'd0);

    always_ff @(posedge clk) begin
        if (rf_push)
            rfifo[rf_wp] <= {ovf_p4, res_i_p4, res_q_p4};
    end

    always_ff @(posedge clk or negedge mrst) begin
        if (!mrst) begin
            rf_wp  <= 3'd0;
            rf_rp  <= 3'd0;
            rf_cnt <= 4'd0;
            ov     <= 1'b0;
            ovf    <= 1'b0;
            dox    <= '0;
            doy    <= '0;
        end else begin
            if (rf_push) rf_wp <= rf_wp + 3'd1;
            if (rf_pop)  rf_rp <= rf_rp + 3'd1;
            rf_cnt <= rf_cnt + {3'd0, rf_push} - {3'd0, rf_pop};
            ov     <= rf_pop;
            if (rf_pop) begin
                ovf <= rfifo[rf_rp][40];
                dox <= rfifo[rf_rp][39:20];
                doy <= rfifo[rf_rp][19:0];
            end
        end
    end
endmodule

// File: tb/tb_pfir_1024x18x25x20x2.sv
// Scoreboard bench for pfir_1024x18x25x20x2. Accepted samples feed a behavioural
// model: a circular history of samples plus the program table. Each complete
// group of dec samples evaluates one pass as plain sums of products. Expected
// results go into a queue, and a monitor pops and compares them on every ov strobe.
module tb_pfir_1024x18x25x20x2;
    logic        clk = 1'b0;
    logic        mrst = 1'b0;
    logic [17:0] dix = '0, diy = '0;
    logic        iv = 1'b0, oe = 1'b1;
    logic        rfd, ov, ovf;
    logic [19:0] dox, doy;
    logic [5:0]  dec = 6'd1;
    logic [9:0]  ncoef = 10'd0;
    logic [8:0]  pdata = '0;
    logic        pwr = 1'b0, prst = 1'b0;

    always #5 clk = ~clk;

    pfir_1024x18x25x20x2 dut (
        .clk(clk), .mrst(mrst), .dix(dix), .diy(diy), .iv(iv), .rfd(rfd),
        .oe(oe), .dox(dox), .doy(doy), .ov(ov), .ovf(ovf), .dec(dec),
        .ncoef(ncoef), .pdata(pdata), .pwr(pwr), .prst(prst)
    );

    typedef struct { int x; int y; bit o; bit chk; } exp_t;
    exp_t expq[$];
    exp_t mon_e;
    int   checks = 0, errors = 0;
    int   ov_cnt = 0, rfd_low = 0, last_x = 0;

    // reference model state
    int m_i[1024], m_q[1024];
    bit m_known[1024];
    int m_ptr = 0, m_pend = 0;
    int p_coef[1024], p_off[1024];
    bit p_w[1024];

    task automatic check(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // floor((a + 2^20) / 2^21), clipped to 20-bit signed
    function automatic int rnd_sat(longint a, output bit clip);
        longint r;
        r = (a + 64'sd1048576) >>> 21;
        clip = 1'b0;
        if (r > 524287)       begin r = 524287;  clip = 1'b1; end
        else if (r < -524288) begin r = -524288; clip = 1'b1; end
        return int'(r);
    endfunction

    task automatic run_pass();
        longint ax = 0, ay = 0;
        bit kn = 1'b1, cx, cy;
        int idx;
        exp_t e;
        for (int k = 0; k <= int'(ncoef) + 1; k++) begin
            idx = (m_ptr - p_off[k]) & 1023;
            kn  = kn & m_known[idx];
            ax += longint'(m_i[idx]) * p_coef[k];
            ay += longint'(m_q[idx]) * p_coef[k];
            if (p_w[k]) begin
                e.x = rnd_sat(ax, cx);
                e.y = rnd_sat(ay, cy);
                e.o = cx | cy;
                e.chk = kn;
                expq.push_back(e);
                ax = 0; ay = 0; kn = 1'b1;
            end
        end
    endtask

    task automatic model_accept(int x, int y, bit gen);
        m_ptr = (m_ptr + 1) & 1023;
        m_i[m_ptr] = x;
        m_q[m_ptr] = y;
        m_known[m_ptr] = 1'b1;
        m_pend++;
        if (m_pend >= ((dec == 6'd0) ? 1 : int'(dec))) begin
            m_pend = 0;
            if (gen) run_pass();
        end
    endtask

    // called at a negedge; iv is high across exactly one posedge
    task automatic send(int x, int y, int gap, bit gen);
        bit acc;
        dix = 18'(x); diy = 18'(y); iv = 1'b1;
        acc = rfd;
        @(negedge clk);
        iv = 1'b0;
        if (acc) model_accept(x, y, gen);
        else rfd_low++;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic set_entry(int k, bit w, int coef, int off);
        p_w[k] = w; p_coef[k] = coef; p_off[k] = off;
    endtask

    task automatic load_prog(int n);
        logic [24:0] c;
        logic [9:0]  o;
        prst = 1'b1; @(negedge clk); prst = 1'b0;
        pwr = 1'b1;
        for (int k = 0; k < n; k++) begin
            c = 25'(p_coef[k]);
            o = 10'(p_off[k]);
            pdata = o[8:0];            @(negedge clk);
            pdata = {c[7:0], o[9]};    @(negedge clk);
            pdata = c[16:8];           @(negedge clk);
            pdata = {p_w[k], c[24:17]}; @(negedge clk);
        end
        pwr = 1'b0;
    endtask

    // 37 entries: entry 0 is one branch, entries 1..36 the other; each has unity gain
    task automatic build_hb();
        int sum = 0, c;
        set_entry(0, 1'b1, 1 << 23, 9);
        for (int k = 1; k < 36; k++) begin
            c = int'($urandom_range(0, 131072)) - 65536;
            set_entry(k, 1'b0, c, k - 1);
            sum += c;
        end
        set_entry(36, 1'b1, (1 << 23) - sum, 35);
        ncoef = 10'd35;
        dec = 6'd1;
        load_prog(37);
    endtask

    task automatic drain(string name);
        int t = 0;
        while (expq.size() != 0 && t < 3000) begin @(negedge clk); t++; end
        repeat (20) @(negedge clk);
        check({name, "_outstanding"}, expq.size(), 0);
        expq.delete();
    endtask

    task automatic rnd_sample(output int x, output int y);
        x = int'($urandom_range(0, 131072)) - 65536;
        y = int'($urandom_range(0, 131072)) - 65536;
    endtask

    always @(negedge clk) begin
        if (mrst && ov) begin
            ov_cnt++;
            last_x = int'($signed(dox));
            if (expq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_output: got (%0d,%0d) ovf=%0d, none expected",
                         $signed(dox), $signed(doy), ovf);
            end else begin
                mon_e = expq.pop_front();
                if (mon_e.chk) begin
                    checks++;
                    if (int'($signed(dox)) != mon_e.x || int'($signed(doy)) != mon_e.y || ovf != mon_e.o) begin
                        errors++;
                        $display("FAIL out: got (%0d,%0d,ovf=%0d) required (%0d,%0d,ovf=%0d)",
                                 $signed(dox), $signed(doy), ovf, mon_e.x, mon_e.y, mon_e.o);
                    end
                end
            end
        end
    end

    initial begin
        exp_t e;
        int x, y, base;
        logic [9:0] ovbits;

        repeat (3) @(negedge clk);
        check("rst_rfd", int'(rfd), 1);
        check("rst_ov", int'(ov), 0);
        check("rst_ovf", int'(ovf), 0);
        check("rst_dox", int'(dox), 0);
        check("rst_doy", int'(doy), 0);
        mrst = 1'b1;
        repeat (2) @(negedge clk);

        // single-tap passthrough, fixed expectations
        set_entry(0, 1'b1, 1 << 23, 0);
        set_entry(1, 1'b1, 0, 0);
        ncoef = 10'd0; dec = 6'd1;
        load_prog(2);
        e.x = 4000; e.y = -4000; e.o = 1'b0; e.chk = 1'b1; expq.push_back(e);
        e.x = 0;    e.y = 0;                               expq.push_back(e);
        send(1000, -1000, 1, 1'b0);
        drain("passthru");

        // saturation with coef just under 2.0
        set_entry(0, 1'b1, 16777215, 0);
        set_entry(1, 1'b0, 0, 0);
        load_prog(2);
        send(131071, -131071, 20, 1'b1);
        send(-131071, 131071, 20, 1'b1);
        drain("sat");

        // x2 interpolator, constant input
        build_hb();
        for (int k = 0; k < 45; k++) send(92681, 92681, 38, 1'b1);
        drain("hb_const");
        check("hb_const_within_64", int'(((last_x - 370724) <= 64) && ((370724 - last_x) <= 64)), 1);

        // same program, random input
        for (int k = 0; k < 40; k++) begin rnd_sample(x, y); send(x, y, 38, 1'b1); end
        drain("hb_rand");

        // rate burst: 16 at 30 clks then 8 at 40 clks
        base = ov_cnt; rfd_low = 0;
        for (int k = 0; k < 24; k++) begin rnd_sample(x, y); send(x, y, (k < 16) ? 30 : 40, 1'b1); end
        drain("burst");
        check("burst_rfd_low", rfd_low, 0);
        check("burst_outputs", ov_cnt - base, 48);

        // decimate by 3, one branch of 12 taps
        for (int k = 0; k < 12; k++)
            set_entry(k, k == 11, int'($urandom_range(0, 2097152)) - 1048576, k);
        ncoef = 10'd10; dec = 6'd3;
        load_prog(12);
        base = ov_cnt;
        for (int k = 0; k < 30; k++) begin rnd_sample(x, y); send(x, y, 15, 1'b1); end
        drain("decim");
        check("decim_outputs", ov_cnt - base, 10);

        // x4 program with oe held low through the pass
        for (int k = 0; k < 4; k++) set_entry(k, 1'b1, 1 << 23, k);
        ncoef = 10'd2; dec = 6'd1;
        load_prog(4);
        oe = 1'b0;
        base = ov_cnt;
        rnd_sample(x, y);
        send(x, y, 60, 1'b1);
        check("oe_hold_ov", ov_cnt - base, 0);
        oe = 1'b1;
        for (int k = 0; k < 10; k++) begin @(negedge clk); ovbits[k] = ov; end
        check("oe_burst_len", $countones(ovbits), 4);
        check("oe_burst_first4", int'(ovbits[3:0]), 15);
        drain("oe");

        // abort mid-pass with mrst
        build_hb();
        rnd_sample(x, y);
        send(x, y, 12, 1'b1);
        mrst = 1'b0;
        expq.delete();
        #1;
        check("abort_rfd", int'(rfd), 1);
        check("abort_ov", int'(ov), 0);
        check("abort_ovf", int'(ovf), 0);
        check("abort_dox", int'(dox), 0);
        check("abort_doy", int'(doy), 0);
        @(negedge clk);
        mrst = 1'b1;
        m_ptr = 0; m_pend = 0;
        base = ov_cnt;
        repeat (60) @(negedge clk);
        check("abort_no_output", ov_cnt - base, 0);

        // program survives mrst; delay pointer restarts at 0
        for (int k = 0; k < 6; k++) begin rnd_sample(x, y); send(x, y, 38, 1'b1); end
        drain("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pfir_1024x18x25x20x2.md
# pfir_1024x18x25x20x2

Programmable dual-channel (I/Q) polyphase FIR engine: 18-bit complex samples in, 20-bit complex samples out. It uses a single time-shared 18x25 MAC per channel and runs up to 1024 program entries per pass, so it can act as an interpolator, decimator or plain filter. It sits between the baseband sample source and the up/down-conversion chain. A nine-bit byte-serial port loads the coefficient program.

## Interface
- No parameters; sizes are fixed: 1024 program entries, 1024-sample delay line per channel.
- clk  in  1  sole clock; all logic, including the programming port, is synchronous to it.
- mrst  in  1  asynchronous, active-low master reset.
- dix, diy  in  18  signed input I/Q sample.
- iv  in  1  input valid; the sample is taken on a clk edge when iv=1 and rfd=1.
- rfd  out  1  ready for data; high when the input FIFO has a free slot.
- oe  in  1  output enable; results are released only while oe=1.
- dox, doy  out  20  signed output I/Q sample.
- ov  out  1  one-cycle output-valid strobe.
- ovf  out  1  saturation occurred in the current dox/doy word; qualified by ov.
- dec  in  6  number of accepted input samples per program pass; 0 is treated as 1.
- ncoef  in  10  program length minus 2; a pass executes entries 0..ncoef+1, so ncoef ≤ 1022.
- pdata  in  9  programming data word.
- pwr  in  1  write strobe for pdata.
- prst  in  1  resets the programming word phase and entry address to 0.

## Operation
- Each program entry is 36 bits: {w, coef[24:0], off[9:0]}. coef is signed Q1.23 (2^23 = 1.0). off is the delay-line offset, where 0 is the newest sample.
- Programming: each pwr cycle stores one word. The four words of an entry are: word0 = off[8:0]; word1 = {coef[7:0], off[9]}; word2 = coef[16:8]; word3 = {w, coef[24:17]}.
  - On word3 the entry is written at the current address, the address increments, and the word phase returns to 0.
  - prst, or mrst asserted, clears both the address and the word phase.
  - Programming during a pass gives undefined filter output but must not hang the block.
- Input: accepted samples go into a 16-deep input FIFO. When dec samples are pending and the sequencer is idle, the sequencer:
  - writes those dec samples into the circular delay lines;
  - clears the accumulators;
  - starts a pass.
- Pass:
  - One entry is issued per clk, in order 0..ncoef+1.
  - Each entry computes acc += dly[newest−off] × coef, separately for I and Q.
  - After an entry with w=1 the accumulator is emitted and then cleared. The w=1 entries therefore delimit polyphase branches, giving N outputs per pass for N w-flags.
- Arithmetic:
  - Products are 43 bits; accumulators are 48 bits.
  - Output = round-half-up(acc / 2^21), saturated to [−524288, 524287]. Unity gain therefore maps an input x to an output of 4x.
  - ovf=1 when that output word was clipped.
- Outputs enter an 8-deep result FIFO. When it is full, new results are dropped and old results are kept.
- Contents that survive mrst: the delay lines and the program RAM are not cleared, so the first outputs after start-up contain stale data.

## Timing
- Reset values: rfd=1, ov=0, ovf=0, dox=doy=0. The input FIFO, result FIFO, sequencer (IDLE) and delay pointer are all cleared.
- Sequencer states:
  - IDLE → LOAD (dec samples pending; one clk per sample written to the delay line).
  - LOAD → RUN (ncoef+2 clks).
  - RUN → IDLE, or RUN → LOAD directly if dec samples are already pending.
  - A 37-entry pass with dec=1 must sustain one input every 38 clks.
- Result latency: a result reaches the result FIFO exactly 6 clks after its w=1 entry issues.
- Output: on a clk edge where oe=1 and the result FIFO is non-empty, dox/doy/ovf load the head entry and ov=1 for that cycle. Otherwise ov=0 and dox/doy hold their values.
- Input acceptance and output release may occur in the same clk.
- iv asserted while rfd=0 is ignored.
- mrst asserted mid-pass aborts immediately; no partial result is released.

## Test plan
- Reset: drive mrst=0 at any point → rfd=1, ov=0, ovf=0, dox=doy=0 within the same cycle.
- Single-tap passthrough: program ncoef=0, entry0={1, 2^23, 0}, entry1={1, 0, 0}; input dix=1000, diy=−1000 → outputs (4000, −4000) then (0, 0).
- Halfband ×2 interpolator: 37 entries, ncoef=35, constant input dix=diy=92681 applied for ≥40 samples at 38-clk spacing → two outputs per input, each within ±64 LSB of 370724.
- Saturation: coef=16777215 (≈2.0), off=0, input ±131071 → dox=524287 with ovf=1, then −524288 with ovf=1.
- oe gating: ×4 program (4 w-flags), hold oe=0 through one pass → ov stays 0. Raise oe → ov=1 for exactly 4 consecutive clks, results in program order.
- Rate burst: 37-entry program, iv every 30 clks for 16 samples, then every 40 clks → rfd never drops, no sample lost, exactly 2 outputs per input.
